// File: rtl/bm_if_result_fifo.sv
// bm_if_result_fifo
//
// Capture stage for the bm_if benchmark outputs. Each result triple
// {out1, out2, out0} is packed into one word and buffered in a small FIFO.
// There is a valid/ready handshake on both the write side and the read side.
// The read side is show-ahead: out_data always shows the head entry.
// Status outputs: occupancy, a sticky drop flag, and a saturating count of
// accepted entries whose out1 bit was set.
//
// Parameters
//   BITS   operand width of out0/out2 (benchmark `BITS)
//   DEPTH  number of FIFO entries; must be a power of two and at least 2
//
// Ports
//   clock      single clock; all state updates on its rising edge
//   reset_n    asynchronous active-low reset; clears pointers, counters,
//              flags and storage
//   in_valid   a result triple is offered
//   in_ready   FIFO has room (depends only on registered occupancy)
//   out0_in    benchmark out0 (BITS)
//   out2_in    benchmark out2 (BITS)
//   out1_in    benchmark out1 (1 bit)
//   out_valid  head entry is available
//   out_ready  consumer takes the head entry
//   out_data   head entry, packed {out1, out2, out0}, with out0 in the LSBs
//   count      number of occupied entries (0..DEPTH)
//   drop_flag  sticky; set when an offer is made while the FIFO is full
//   hi_count   saturating count of accepted entries with out1_in = 1

module bm_if_result_fifo #(
    parameter int BITS  = 2,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BITS-1:0]            out0_in,
    input  logic [BITS-1:0]            out2_in,
    input  logic                       out1_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2*BITS:0]            out_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       drop_flag,
    output logic [7:0]                 hi_count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int DATA_W = 2 * BITS + 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    // Catch a bad DEPTH at elaboration time; never generates hardware.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
        $error("bm_if_result_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              drop_q,   drop_d;
    logic [7:0]        hi_q,     hi_d;

    logic              push;
    logic              pop;
    logic [DATA_W-1:0] wr_data;

    // in_ready and out_valid depend only on registered occupancy.
    // So a full FIFO refuses a push even in a cycle where it also pops.
    assign in_ready  = (count_q != CNT_FULL);
    assign out_valid = (count_q != '0);

    assign push    = in_valid && in_ready;
    assign pop     = out_valid && out_ready;
    assign wr_data = {out1_in, out2_in, out0_in};

    // Next-state logic for pointers, occupancy and status.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        hi_d     = hi_q;

        // Wrap is written out explicitly so the intent is clear.
        // For a power-of-two DEPTH it reduces to a plain increment.
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (in_valid && !in_ready) begin
            drop_d = 1'b1;
        end

        if (push && out1_in && (hi_q != 8'hFF)) begin
            hi_d = hi_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= 1'b0;
            hi_q     <= 8'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
            hi_q     <= hi_d;
        end
    end

    // Storage is cleared on reset, so out_data reads 0 (never X)
    // until the first entry is written.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign drop_flag = drop_q;
    assign hi_count  = hi_q;

endmodule
